// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive path.
//   parity_mode_t : line parity selection (NONE/EVEN/ODD, 2'b11 reserved and treated as NONE)
//   rx_state_t    : receiver FSM states
//   IDLE_LEVEL    : logic level of an idle serial line
//   maj3()        : 2-of-3 majority used for noise rejection on oversampled bits
package uart_pkg;

   typedef enum logic [1:0] {
      PARITY_NONE = 2'b00,
      PARITY_EVEN = 2'b01,
      PARITY_ODD  = 2'b10,
      PARITY_RSVD = 2'b11
   } parity_mode_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } rx_state_t;

   localparam logic IDLE_LEVEL = 1'b1;

   function automatic logic maj3(input logic [2:0] v);
      return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
   endfunction

endpackage

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if: receive-side delivery interface between the UART receiver
// and the register/FIFO layer.
//   rx_data_o      received byte (DATA_BITS wide)
//   rx_valid_o     data valid, held until accepted
//   rx_ready_i     consumer ready
//   busy_o         receiver is inside a frame
//   parity_err_o   1-cycle pulse, parity mismatch on a delivered frame
//   frame_err_o    1-cycle pulse, stop bit sampled low
//   overrun_err_o  1-cycle pulse, frame completed while previous data unaccepted
// master = receiver core, slave = consumer.
interface uart_rx_core_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] rx_data_o;
   logic                 rx_valid_o;
   logic                 rx_ready_i;
   logic                 busy_o;
   logic                 parity_err_o;
   logic                 frame_err_o;
   logic                 overrun_err_o;

   modport master (
      output rx_data_o, rx_valid_o, busy_o, parity_err_o, frame_err_o, overrun_err_o,
      input  rx_ready_i
   );

   modport slave (
      input  rx_data_o, rx_valid_o, busy_o, parity_err_o, frame_err_o, overrun_err_o,
      output rx_ready_i
   );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for an asynchronous single-bit input.
//   clk_i    in   destination clock
//   reset_i  in   synchronous active-high reset, loads RESET_VAL into both flops
//   async_i  in   asynchronous input
//   sync_o   out  synchronized output
module uart_rx_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk_i,
   input  logic reset_i,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampled UART receiver.
// Detects a start bit on the asynchronous rx line, samples data/parity/stop at
// bit centres using an OSR-rate tick with 3-sample majority voting, and delivers
// bytes over a valid/ready interface.
//   clk_i          in   system clock
//   reset_i        in   synchronous active-high reset
//   enable_i       in   receiver enable; low aborts any frame and holds IDLE
//   osr_tick_i     in   1-cycle pulse at OSR x baud
//   rx_i           in   asynchronous serial line, idle high
//   parity_mode_i  in   parity selection, latched at start detect
//   rx_if          master side of uart_rx_core_if (data/valid/ready, busy, error pulses)
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int OSR       = 16,
   parameter int DATA_BITS = 8
) (
   input  logic           clk_i,
   input  logic           reset_i,
   input  logic           enable_i,
   input  logic           osr_tick_i,
   input  logic           rx_i,
   input  parity_mode_t   parity_mode_i,
   uart_rx_core_if.master rx_if
);

   localparam int OS_W = $clog2(OSR);
   localparam int BC_W = $clog2(DATA_BITS + 1);
   localparam logic [OS_W-1:0] OS_HALF = OS_W'(OSR / 2 - 1);
   localparam logic [OS_W-1:0] OS_LAST = OS_W'(OSR - 1);
   localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

   logic rx_s;

   rx_state_t            state_q, state_d;
   logic [OS_W-1:0]      os_cnt_q, os_cnt_d;
   logic [BC_W-1:0]      bit_cnt_q, bit_cnt_d;
   logic [2:0]           vote_q, vote_d;
   parity_mode_t         par_mode_q, par_mode_d;
   logic                 par_bad_q, par_bad_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 par_err_q, par_err_d;
   logic                 frame_err_q, frame_err_d;
   logic                 ovr_err_q, ovr_err_d;

   logic bit_v;
   logic par_en;
   logic par_exp;
   logic complete;

   uart_rx_sync #(.RESET_VAL(IDLE_LEVEL)) u_sync (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .async_i(rx_i),
      .sync_o (rx_s)
   );

   assign bit_v   = maj3(vote_q);
   // Reserved mode 2'b11 falls through as no parity.
   assign par_en  = (par_mode_q == PARITY_EVEN) || (par_mode_q == PARITY_ODD);
   assign par_exp = (par_mode_q == PARITY_EVEN) ? ^shift_q : ~^shift_q;

   always_comb begin
      state_d     = state_q;
      os_cnt_d    = os_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      vote_d      = vote_q;
      par_mode_d  = par_mode_q;
      par_bad_d   = par_bad_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = valid_q;
      par_err_d   = 1'b0;
      frame_err_d = 1'b0;
      ovr_err_d   = 1'b0;
      complete    = 1'b0;

      if (valid_q && rx_if.rx_ready_i) begin
         valid_d = 1'b0;
      end

      if (!enable_i) begin
         state_d   = ST_IDLE;
         os_cnt_d  = '0;
         bit_cnt_d = '0;
      end else if (osr_tick_i) begin
         vote_d = {vote_q[1:0], rx_s};
         unique case (state_q)
            ST_IDLE: begin
               if (rx_s != IDLE_LEVEL) begin
                  state_d    = ST_START;
                  os_cnt_d   = '0;
                  par_mode_d = parity_mode_i;
                  par_bad_d  = 1'b0;
               end
            end
            ST_START: begin
               if (os_cnt_q == OS_HALF) begin
                  os_cnt_d = '0;
                  // A start edge that is no longer low at mid-bit was a glitch.
                  if (bit_v == IDLE_LEVEL) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d   = ST_DATA;
                     bit_cnt_d = '0;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + OS_W'(1);
               end
            end
            ST_DATA: begin
               if (os_cnt_q == OS_LAST) begin
                  os_cnt_d  = '0;
                  shift_d   = {bit_v, shift_q[DATA_BITS-1:1]};
                  bit_cnt_d = bit_cnt_q + BC_W'(1);
                  if (bit_cnt_q == BC_LAST) begin
                     state_d = par_en ? ST_PARITY : ST_STOP;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + OS_W'(1);
               end
            end
            ST_PARITY: begin
               if (os_cnt_q == OS_LAST) begin
                  os_cnt_d  = '0;
                  par_bad_d = (bit_v != par_exp);
                  state_d   = ST_STOP;
               end else begin
                  os_cnt_d = os_cnt_q + OS_W'(1);
               end
            end
            ST_STOP: begin
               if (os_cnt_q == OS_LAST) begin
                  os_cnt_d = '0;
                  // Return to IDLE mid-stop so a back-to-back start edge is not missed.
                  if (bit_v == IDLE_LEVEL) begin
                     state_d  = ST_IDLE;
                     complete = 1'b1;
                  end else begin
                     state_d     = ST_BREAK;
                     frame_err_d = 1'b1;
                  end
               end else begin
                  os_cnt_d = os_cnt_q + OS_W'(1);
               end
            end
            ST_BREAK: begin
               if (rx_s == IDLE_LEVEL) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d  = ST_IDLE;
               os_cnt_d = '0;
            end
         endcase
      end

      // A consume in the same cycle frees the slot, so the new byte wins without overrun.
      if (complete) begin
         if (!valid_q || rx_if.rx_ready_i) begin
            data_d    = shift_q;
            valid_d   = 1'b1;
            par_err_d = par_bad_q;
         end else begin
            ovr_err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         os_cnt_q    <= '0;
         bit_cnt_q   <= '0;
         vote_q      <= 3'b111;
         par_mode_q  <= PARITY_NONE;
         par_bad_q   <= 1'b0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         par_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
         ovr_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         os_cnt_q    <= os_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         vote_q      <= vote_d;
         par_mode_q  <= par_mode_d;
         par_bad_q   <= par_bad_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         par_err_q   <= par_err_d;
         frame_err_q <= frame_err_d;
         ovr_err_q   <= ovr_err_d;
      end
   end

   // Shift register carries only datapath bits; every frame overwrites it fully.
   always_ff @(posedge clk_i) begin
      shift_q <= shift_d;
   end

   assign rx_if.rx_data_o     = data_q;
   assign rx_if.rx_valid_o    = valid_q;
   assign rx_if.busy_o        = (state_q != ST_IDLE);
   assign rx_if.parity_err_o  = par_err_q;
   assign rx_if.frame_err_o   = frame_err_q;
   assign rx_if.overrun_err_o = ovr_err_q;

endmodule
